// File: rtl/vote_tally.sv
// Push-button vote counter: per-button sync/debounce/edge-detect feeding an IDLE/VOTING/DONE session FSM.
// Define VOTE_TIMEOUT_EN to close the voting window automatically after TIMEOUT_CYCLES clocks.
module vote_tally #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [3:0]  MAX_VOTERS      = 4'd9,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_agree,
    input  logic       btn_disagree,
    input  logic       btn_start,
    output logic [3:0] agree,
    output logic [3:0] disagree,
    output logic       voting,
    output logic       result_valid,
    output logic       passed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VOTING = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] DEB_LAST = DEBOUNCE_CYCLES - 16'd1;

    // Bit order shared by every per-button vector: 0 agree, 1 disagree, 2 start.
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_start, btn_disagree, btn_agree};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cond
            logic        sync1_reg;
            logic        sync2_reg;
            logic        deb_reg;
            logic        deb_d_reg;
            logic [15:0] cnt_reg;

            // Counter only runs while the synchronized level disagrees with the
            // accepted level, so any bounce back restarts the stability window.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            end

            assign press[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

    logic       agree_p;
    logic       disagree_p;
    logic       start_p;

    assign agree_p    = press[0];
    assign disagree_p = press[1];
    assign start_p    = press[2];

    state_t     state_reg;
    logic [3:0] agree_reg;
    logic [3:0] disagree_reg;
    logic       voting_reg;
    logic       result_valid_reg;
    logic       passed_reg;

    logic [3:0] total;
    logic       ballot_a;
    logic       ballot_d;
    logic [3:0] agree_next;
    logic [3:0] disagree_next;
    logic       cap_hit;
    logic       timeout_hit;

    // A simultaneous agree+disagree is an invalid ballot; the cap guard keeps
    // the running total from ever exceeding MAX_VOTERS.
    always_comb begin
        total         = agree_reg + disagree_reg;
        ballot_a      = agree_p & ~disagree_p & (total < MAX_VOTERS);
        ballot_d      = disagree_p & ~agree_p & (total < MAX_VOTERS);
        agree_next    = agree_reg + {3'b000, ballot_a};
        disagree_next = disagree_reg + {3'b000, ballot_d};
        cap_hit       = (ballot_a | ballot_d) & ((total + 4'd1) == MAX_VOTERS);
    end

`ifdef VOTE_TIMEOUT_EN
    logic [31:0] win_cnt_reg;
    logic        leave_voting;

    assign timeout_hit  = (state_reg == VOTING) && (win_cnt_reg == (TIMEOUT_CYCLES - 32'd1));
    assign leave_voting = start_p | cap_hit | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg <= '0;
        end else if ((state_reg == VOTING) && !leave_voting) begin
            win_cnt_reg <= win_cnt_reg + 32'd1;
        end else begin
            win_cnt_reg <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            agree_reg        <= '0;
            disagree_reg     <= '0;
            voting_reg       <= 1'b0;
            result_valid_reg <= 1'b0;
            passed_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_p) begin
                        state_reg    <= VOTING;
                        agree_reg    <= '0;
                        disagree_reg <= '0;
                        voting_reg   <= 1'b1;
                    end
                end
                VOTING: begin
                    if (start_p) begin
                        state_reg        <= DONE;
                        voting_reg       <= 1'b0;
                        result_valid_reg <= 1'b1;
                        passed_reg       <= (agree_reg > disagree_reg);
                    end else begin
                        agree_reg    <= agree_next;
                        disagree_reg <= disagree_next;
                        // The closing ballot must be reflected in the verdict.
                        if (cap_hit || timeout_hit) begin
                            state_reg        <= DONE;
                            voting_reg       <= 1'b0;
                            result_valid_reg <= 1'b1;
                            passed_reg       <= (agree_next > disagree_next);
                        end
                    end
                end
                DONE: begin
                    if (start_p) begin
                        state_reg        <= VOTING;
                        agree_reg        <= '0;
                        disagree_reg     <= '0;
                        voting_reg       <= 1'b1;
                        result_valid_reg <= 1'b0;
                        passed_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    voting_reg       <= 1'b0;
                    result_valid_reg <= 1'b0;
                    passed_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign agree        = agree_reg;
    assign disagree     = disagree_reg;
    assign voting       = voting_reg;
    assign result_valid = result_valid_reg;
    assign passed       = passed_reg;

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally: stimulus queues expected output snapshots, monitors pop on each output change.
// Default build exercises sessions, debounce, cap and reset; VOTE_TIMEOUT_EN build exercises the window timeout.
module tb_vote_tally;

    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
        logic       v;
        logic       rv;
        logic       p;
        int         cyc;
    } snap_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn0;
    logic [2:0] btn1;
    logic [3:0] agree0, disagree0, agree1, disagree1;
    logic       voting0, rv0, passed0, voting1, rv1, passed1;

    int    checks;
    int    errors;
    int    cyc;
    snap_t q0[$];
    snap_t q1[$];
    logic [10:0] prev0;
    logic [10:0] prev1;

    vote_tally #(
        .DEBOUNCE_CYCLES(16'd4),
        .MAX_VOTERS     (4'd9),
        .TIMEOUT_CYCLES (32'd100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_agree   (btn0[0]),
        .btn_disagree(btn0[1]),
        .btn_start   (btn0[2]),
        .agree       (agree0),
        .disagree    (disagree0),
        .voting      (voting0),
        .result_valid(rv0),
        .passed      (passed0)
    );

    vote_tally #(
        .DEBOUNCE_CYCLES(16'd4),
        .MAX_VOTERS     (4'd5),
        .TIMEOUT_CYCLES (32'd100)
    ) dut_cap (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_agree   (btn1[0]),
        .btn_disagree(btn1[1]),
        .btn_start   (btn1[2]),
        .agree       (agree1),
        .disagree    (disagree1),
        .voting      (voting1),
        .result_valid(rv1),
        .passed      (passed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare_snap(input string name, input logic [10:0] got, input snap_t e);
        logic [10:0] exp_v;
        exp_v = {e.a, e.d, e.v, e.rv, e.p};
        checks++;
        if (got !== exp_v || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s: got a=%0d d=%0d v=%0d rv=%0d p=%0d at cycle %0d, expected a=%0d d=%0d v=%0d rv=%0d p=%0d at cycle %0d",
                     name, got[10:7], got[6:3], got[2], got[1], got[0], cyc,
                     e.a, e.d, e.v, e.rv, e.p, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] cur;
        snap_t       e;
        cur = {agree0, disagree0, voting0, rv0, passed0};
        if (cur !== prev0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: outputs changed to a=%0d d=%0d v=%0d rv=%0d p=%0d at cycle %0d, expected no change",
                         cur[10:7], cur[6:3], cur[2], cur[1], cur[0], cyc);
            end else begin
                e = q0.pop_front();
                compare_snap("main", cur, e);
            end
            prev0 = cur;
        end
    end

    always @(negedge clk) begin
        logic [10:0] cur;
        snap_t       e;
        cur = {agree1, disagree1, voting1, rv1, passed1};
        if (cur !== prev1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cap_unexpected: outputs changed to a=%0d d=%0d v=%0d rv=%0d p=%0d at cycle %0d, expected no change",
                         cur[10:7], cur[6:3], cur[2], cur[1], cur[0], cyc);
            end else begin
                e = q1.pop_front();
                compare_snap("cap", cur, e);
            end
            prev1 = cur;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int unit, input int a, input int d, input int v, input int rv, input int p, input int c);
        snap_t s;
        s.a   = 4'(a);
        s.d   = 4'(d);
        s.v   = 1'(v);
        s.rv  = 1'(rv);
        s.p   = 1'(p);
        s.cyc = c;
        if (unit == 0) q0.push_back(s);
        else           q1.push_back(s);
    endtask

    // Clean press: held long enough to debounce, released long enough to settle.
    task automatic press(input int unit, input logic [2:0] m);
        if (unit == 0) btn0 = m;
        else           btn1 = m;
        step(10);
        if (unit == 0) btn0 = 3'b000;
        else           btn1 = 3'b000;
        step(10);
    endtask

    task automatic check_val(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev0  = '0;
        prev1  = '0;
        btn0   = 3'b000;
        btn1   = 3'b000;
        rst_n  = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        check_val("reset_outputs", int'({agree0, disagree0, voting0, rv0, passed0}), 0);
        check_val("reset_outputs_cap", int'({agree1, disagree1, voting1, rv1, passed1}), 0);

`ifdef VOTE_TIMEOUT_EN
        begin
            int t_enter;
            t_enter = cyc + 7;
            push(0, 0, 0, 1, 0, 0, t_enter);
            press(0, 3'b100);
            push(0, 1, 0, 1, 0, 0, cyc + 7);
            push(0, 1, 0, 0, 1, 1, t_enter + 100);
            press(0, 3'b001);
            step(100);
            check_val("timeout_result_valid", int'(rv0), 1);
        end
`else
        // Ballots while idle are ignored.
        press(0, 3'b001);
        check_val("idle_agree", int'(agree0), 0);

        // Session 1: 3 agree, 2 disagree, early close.
        push(0, 0, 0, 1, 0, 0, cyc + 7);
        press(0, 3'b100);
        for (int k = 1; k <= 3; k++) begin
            push(0, k, 0, 1, 0, 0, cyc + 7);
            press(0, 3'b001);
        end
        for (int k = 1; k <= 2; k++) begin
            push(0, 3, k, 1, 0, 0, cyc + 7);
            press(0, 3'b010);
        end
        push(0, 3, 2, 0, 1, 1, cyc + 7);
        press(0, 3'b100);

        // Session 2: tie gives passed=0.
        push(0, 0, 0, 1, 0, 0, cyc + 7);
        press(0, 3'b100);
        push(0, 1, 0, 1, 0, 0, -1);
        press(0, 3'b001);
        push(0, 2, 0, 1, 0, 0, -1);
        press(0, 3'b001);
        push(0, 2, 1, 1, 0, 0, -1);
        press(0, 3'b010);
        push(0, 2, 2, 1, 0, 0, -1);
        press(0, 3'b010);
        push(0, 2, 2, 0, 1, 0, -1);
        press(0, 3'b100);

        // Session 3: glitchy agree yields one increment, 7 cycles after the stable edge.
        push(0, 0, 0, 1, 0, 0, -1);
        press(0, 3'b100);
        btn0[0] = 1'b1;
        step(3);
        btn0[0] = 1'b0;
        step(2);
        push(0, 1, 0, 1, 0, 0, cyc + 7);
        btn0[0] = 1'b1;
        step(12);
        btn0[0] = 1'b0;
        step(10);

        // Simultaneous ballot is invalid; then close, ignore ballots in DONE, restart.
        press(0, 3'b011);
        check_val("simul_agree", int'(agree0), 1);
        check_val("simul_disagree", int'(disagree0), 0);
        push(0, 1, 0, 0, 1, 1, -1);
        press(0, 3'b100);
        press(0, 3'b001);
        press(0, 3'b010);
        push(0, 0, 0, 1, 0, 0, cyc + 7);
        press(0, 3'b100);

        // Reset mid-session discards the tally immediately.
        push(0, 1, 0, 1, 0, 0, -1);
        press(0, 3'b001);
        push(0, 0, 0, 0, 0, 0, -1);
        rst_n = 1'b0;
        #1;
        check_val("async_reset", int'({agree0, disagree0, voting0, rv0, passed0}), 0);
        step(3);
        rst_n = 1'b1;
        step(2);
        press(0, 3'b001);
        check_val("post_reset_idle_agree", int'(agree0), 0);

        // Cap of 5: the fifth agree closes the session on the same edge.
        push(1, 0, 0, 1, 0, 0, -1);
        press(1, 3'b100);
        for (int k = 1; k <= 7; k++) begin
            if (k < 5)       push(1, k, 0, 1, 0, 0, cyc + 7);
            else if (k == 5) push(1, 5, 0, 0, 1, 1, cyc + 7);
            press(1, 3'b001);
        end
        check_val("cap_agree", int'(agree1), 5);
        check_val("cap_result_valid", int'(rv1), 1);
`endif

        step(20);
        check_val("main_queue_drained", q0.size(), 0);
        check_val("cap_queue_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
